// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the digit-serial subtractor.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One extra bit so the counter can never wrap before the last digit is seen.
  function automatic int cnt_width(input int ndig);
    return $clog2(ndig) + 1;
  endfunction

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic d_msb);
    return (a_msb != b_msb) && (d_msb != a_msb);
  endfunction

endpackage

// File: rtl/serial_subtractor_sub_digit.sv
// Combinational DIGIT-bit full subtractor slice: {bout, d} = x - y - bin.
module serial_subtractor_sub_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  logic [DIGIT:0] full_s;

  assign full_s = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, bin};
  assign d      = full_s[DIGIT-1:0];
  assign bout   = full_s[DIGIT];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b, DIGIT bits per clock, LSB first,
// with valid/ready handshakes on both sides.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if ((DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
    $error("serial_subtractor: WIDTH must be a multiple of DIGIT and 1 <= DIGIT <= WIDTH");
  end

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_sr_r, b_sr_r, res_r;
  logic             bin_r, a_msb_r, b_msb_r;
  logic [WIDTH:0]   diff_r;
  logic             borrow_r, ovf_r, in_ready_r, out_valid_r;

  logic [DIGIT-1:0] d_s;
  logic             bout_s;
  logic [WIDTH-1:0] a_shift_s, b_shift_s, res_next_s;

  serial_subtractor_sub_digit #(.DIGIT(DIGIT)) u_sub_digit (
    .x    (a_sr_r[DIGIT-1:0]),
    .y    (b_sr_r[DIGIT-1:0]),
    .bin  (bin_r),
    .d    (d_s),
    .bout (bout_s)
  );

  // Operands shift right by one digit; the new result digit enters at the top.
  for (genvar i = 0; i < WIDTH; i++) begin : g_shift
    if (i < WIDTH - DIGIT) begin : g_low
      assign a_shift_s[i]  = a_sr_r[i+DIGIT];
      assign b_shift_s[i]  = b_sr_r[i+DIGIT];
      assign res_next_s[i] = res_r[i+DIGIT];
    end else begin : g_top
      assign a_shift_s[i]  = 1'b0;
      assign b_shift_s[i]  = 1'b0;
      assign res_next_s[i] = d_s[i-(WIDTH-DIGIT)];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      a_sr_r      <= '0;
      b_sr_r      <= '0;
      res_r       <= '0;
      bin_r       <= 1'b0;
      a_msb_r     <= 1'b0;
      b_msb_r     <= 1'b0;
      diff_r      <= '0;
      borrow_r    <= 1'b0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            a_sr_r     <= a;
            b_sr_r     <= b;
            a_msb_r    <= a[WIDTH-1];
            b_msb_r    <= b[WIDTH-1];
            res_r      <= '0;
            bin_r      <= 1'b0;
            cnt_r      <= '0;
            in_ready_r <= 1'b0;
            state_r    <= RUN;
          end
        end
        RUN: begin
          a_sr_r <= a_shift_s;
          b_sr_r <= b_shift_s;
          res_r  <= res_next_s;
          bin_r  <= bout_s;
          cnt_r  <= cnt_r + CW'(1);
          if (cnt_r == LAST) begin
            diff_r      <= {bout_s, res_next_s};
            borrow_r    <= bout_s;
            ovf_r       <= signed_ovf(a_msb_r, b_msb_r, res_next_s[WIDTH-1]);
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          // Result stays parked here until the consumer takes it.
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign diff      = diff_r;
  assign borrow    = borrow_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench: directed and random subtractions against an arithmetic
// reference, on a bit-serial (DIGIT=1) and a nibble-serial (DIGIT=4) instance.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       in_valid1, in_ready1, out_valid1, out_ready1, borrow1, ovf1;
  logic [7:0] a1, b1;
  logic [8:0] diff1;
  logic       in_valid4, in_ready4, out_valid4, out_ready4, borrow4, ovf4;
  logic [7:0] a4, b4;
  logic [8:0] diff4;

  int n_cmp = 0;
  int n_err = 0;

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .a(a1), .b(b1),
    .out_valid(out_valid1), .out_ready(out_ready1), .diff(diff1), .borrow(borrow1), .ovf(ovf1));

  serial_subtractor #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .out_valid(out_valid4), .out_ready(out_ready4), .diff(diff4), .borrow(borrow4), .ovf(ovf4));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, borrow, diff[8:0]} from plain integer arithmetic.
  function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b);
    int ua, ub, sa, sb, ud, sd;
    logic [8:0] d;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    ud = ua - ub;
    sd = sa - sb;
    d  = 9'(ud);
    return {(sd > 127 || sd < -128), (ua < ub), d};
  endfunction

  task automatic op1(input logic [7:0] a, input logic [7:0] b, input logic [8:0] ed,
                     input logic eb, input logic eo, input int hold);
    int t, lat;
    t = 0;
    while (!in_ready1 && t < 20) begin @(posedge clk); #1; t++; end
    check("rdy_before_op", in_ready1, 1);
    a1 = a; b1 = b; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0; a1 = 8'($urandom); b1 = 8'($urandom);
    lat = 0;
    while (!out_valid1 && lat < 40) begin @(posedge clk); #1; lat++; end
    check("latency", lat, 8);
    for (int h = 0; h < hold; h++) begin
      in_valid1 = 1'b1;
      @(posedge clk); #1;
      in_valid1 = 1'b0;
      check("hold_diff", diff1, ed);
      check("hold_in_ready", in_ready1, 0);
      check("hold_out_valid", out_valid1, 1);
    end
    check("diff", diff1, ed);
    check("borrow", borrow1, eb);
    check("ovf", ovf1, eo);
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    check("post_out_valid", out_valid1, 0);
    check("post_in_ready", in_ready1, 1);
    check("diff_kept", diff1, ed);
  endtask

  // Scoreboard for the DIGIT=4 instance, sampled on the falling edge.
  logic [10:0] exp_q[$];
  int          acc_q[$];
  int          cyc = 0;
  int          n_res4 = 0;
  int          last_out = 0;

  always @(negedge clk) begin
    logic [10:0] e;
    int          acc;
    cyc++;
    if (rst_n) begin
      if (in_valid4 && in_ready4) begin
        exp_q.push_back(model(a4, b4));
        acc_q.push_back(cyc);
      end
      if (out_valid4) begin
        if (exp_q.size() == 0) begin
          check("d4_unexpected_result", 0, 1);
        end else begin
          e   = exp_q.pop_front();
          acc = acc_q.pop_front();
          check("d4_result", {ovf4, borrow4, diff4}, e);
          check("d4_latency", cyc - acc, 3);
          if (n_res4 == 0) check("d4_first_diff", diff4, 9'h091);
          else             check("d4_period", cyc - last_out, 4);
        end
        last_out = cyc;
        n_res4++;
      end
    end
  end

  initial begin
    logic [10:0] m;
    logic        rb;
    int          t;
    rst_n = 1'b0;
    in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = 8'd0; b1 = 8'd0;
    in_valid4 = 1'b0; out_ready4 = 1'b1; a4 = 8'd0; b4 = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready1, 1);
    check("rst_out_valid", out_valid1, 0);
    check("rst_diff", diff1, 0);
    check("rst_flags", {borrow1, ovf1}, 0);
    check("rst_d4_in_ready", in_ready4, 1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op1(8'd10,  8'd3,   9'h007, 1'b0, 1'b0, 5);
    op1(8'd3,   8'd10,  9'h1F9, 1'b1, 1'b0, 0);
    op1(8'd0,   8'd255, 9'h101, 1'b1, 1'b0, 0);
    op1(8'h80,  8'h01,  9'h07F, 1'b0, 1'b1, 0);
    op1(8'h7F,  8'hFF,  9'h180, 1'b1, 1'b1, 2);
    for (int k = 0; k < 25; k++) begin
      a1 = 8'($urandom); b1 = 8'($urandom);
      m = model(a1, b1);
      op1(a1, b1, m[8:0], m[9], m[10], int'($urandom_range(0, 2)));
    end

    // Abort mid-run: reset while the counter is at 4.
    a1 = 8'd77; b1 = 8'd12; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid1, 0);
    check("abort_in_ready", in_ready1, 1);
    check("abort_diff", diff1, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    op1(8'd5, 8'd5, 9'h000, 1'b0, 1'b0, 0);

    // DIGIT=4 instance: in_valid held high, out_ready tied high.
    for (int k = 0; k < 21; k++) begin
      if (k == 0) begin a4 = 8'd200; b4 = 8'd55; end
      else begin a4 = 8'($urandom); b4 = 8'($urandom); end
      in_valid4 = 1'b1;
      t = 0;
      rb = 1'b0;
      while (!rb && t < 30) begin
        rb = in_ready4;
        @(posedge clk); #1;
        t++;
      end
      if (!rb) check("d4_accept_timeout", 0, 1);
    end
    in_valid4 = 1'b0;
    t = 0;
    while (n_res4 < 21 && t < 100) begin @(posedge clk); #1; t++; end
    check("d4_result_count", n_res4, 21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
